// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: owner-state values and
// requester identifiers used by the "last granted" bookkeeping.
package dmem_arbiter_pkg;

    // Owner FSM encoding: who held the memory port in the previous cycle.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CPU  = 2'd1;
    localparam logic [1:0] ST_DMA  = 2'd2;

    // Requester identifiers for the round-robin "last" register.
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

endpackage

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the CPU load/store port and a
// DMA/loader port. Grants are combinational from registered ownership state
// plus the current requests, so a granted access completes in the same cycle
// with no added latency. DMA bursts are bounded so a waiting CPU is stalled
// for at most MAX_BURST cycles.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              reset,
    // CPU load/store port
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    // DMA/loader port
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_gnt,
    // Memory side
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int               CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    logic [1:0]       r_state;
    logic             r_last;
    logic [CNT_W-1:0] r_burst_cnt;

    logic             w_cpu_wins_tie;
    logic             w_cpu_gnt;
    logic             w_dma_gnt;
    logic [1:0]       w_state_next;
    logic             w_last_next;
    logic [CNT_W-1:0] w_burst_cnt_next;

    // Decide who wins when both sides request: the CPU keeps a port it already
    // owns, reclaims it once the DMA burst limit is reached, and wins from idle
    // when the DMA was the last one served.
    always_comb begin
        w_cpu_wins_tie = 1'b0;
        case (r_state)
            ST_CPU:  w_cpu_wins_tie = 1'b1;
            ST_DMA:  w_cpu_wins_tie = (r_burst_cnt == MAX_CNT);
            default: w_cpu_wins_tie = (r_last == REQ_DMA);
        endcase
    end

    // One-hot (or zero) grant: a lone requester always wins.
    always_comb begin
        w_cpu_gnt = cpu_req & (~dma_req | w_cpu_wins_tie);
        w_dma_gnt = dma_req & ~w_cpu_gnt;
    end

    // Next ownership, round-robin history and CPU-starvation counter.
    always_comb begin
        w_state_next     = ST_IDLE;
        w_last_next      = r_last;
        w_burst_cnt_next = '0;
        if (w_cpu_gnt) begin
            w_state_next = ST_CPU;
            w_last_next  = REQ_CPU;
        end else if (w_dma_gnt) begin
            w_state_next = ST_DMA;
            w_last_next  = REQ_DMA;
        end
        // The counter only runs while the CPU is actually being held off.
        if (w_dma_gnt && cpu_req) begin
            if (r_burst_cnt != MAX_CNT) begin
                w_burst_cnt_next = r_burst_cnt + 1'b1;
            end else begin
                w_burst_cnt_next = r_burst_cnt;
            end
        end
    end

    // Ownership registers; reset leaves the DMA as "last" so the CPU wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_last      <= REQ_DMA;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_last      <= w_last_next;
            r_burst_cnt <= w_burst_cnt_next;
        end
    end

    // Memory mux: the granted side drives the memory; the CPU side is the
    // default when nobody is granted, with the write enable forced low.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        if (w_dma_gnt) begin
            mem_we    = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end else if (w_cpu_gnt) begin
            mem_we    = cpu_we;
        end
    end

    // Read data fans out to both sides; consumers qualify it with their grant.
    assign cpu_rdata = mem_rdata;
    assign dma_rdata = mem_rdata;
    assign cpu_gnt   = w_cpu_gnt;
    assign dma_gnt   = w_dma_gnt;
    assign cpu_stall = cpu_req & ~w_cpu_gnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: the driver computes each cycle's expected
// response from a history-based reference model and queues it; a monitor on
// the falling edge pops and compares against the DUT outputs.
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MB = 8;

    logic          clk = 1'b1;
    always #5 clk = ~clk;

    logic          reset;
    logic          cpu_req, cpu_we, cpu_gnt, cpu_stall;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          dma_req, dma_we, dma_gnt;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata, dma_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_gnt(dma_gnt),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Environment memory: combinational read, synchronous write.
    logic [DW-1:0] tb_mem [0:255];
    assign mem_rdata = tb_mem[mem_addr[9:2]];
    always @(posedge clk) if (mem_we) tb_mem[mem_addr[9:2]] <= mem_wdata;

    typedef struct {
        logic          cpu_gnt;
        logic          dma_gnt;
        logic          cpu_stall;
        logic          mem_we;
        logic [AW-1:0] mem_addr;
        logic [DW-1:0] mem_wdata;
        logic          chk_cpu_rd;
        logic [DW-1:0] cpu_rd;
        logic          chk_dma_rd;
        logic [DW-1:0] dma_rd;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: who was served last cycle, who was served most
    // recently overall, how long the CPU has been kept waiting, and the
    // expected memory contents.
    int            m_prev_owner;   // 0 none, 1 cpu, 2 dma
    bit            m_last_dma;
    int            m_cpu_wait;
    logic [DW-1:0] ref_mem [0:255];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic drive(input logic rst,
                         input logic creq, input logic cwe, input logic [AW-1:0] caddr, input logic [DW-1:0] cwd,
                         input logic dreq, input logic dwe, input logic [AW-1:0] daddr, input logic [DW-1:0] dwd);
        exp_t e;
        bit   g_cpu, g_dma, cpu_first;
        reset = rst;
        cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
        dma_req = dreq; dma_we = dwe; dma_addr = daddr; dma_wdata = dwd;
        if (creq && dreq) begin
            cpu_first = (m_prev_owner == 1) ||
                        (m_prev_owner == 2 && m_cpu_wait >= MB) ||
                        (m_prev_owner == 0 && m_last_dma);
            g_cpu = cpu_first;
            g_dma = !cpu_first;
        end else begin
            g_cpu = creq;
            g_dma = dreq;
        end
        e.cpu_gnt    = g_cpu;
        e.dma_gnt    = g_dma;
        e.cpu_stall  = creq && !g_cpu;
        e.mem_we     = (g_cpu && cwe) || (g_dma && dwe);
        e.mem_addr   = g_dma ? daddr : caddr;
        e.mem_wdata  = g_dma ? dwd : cwd;
        e.chk_cpu_rd = g_cpu && !cwe;
        e.cpu_rd     = ref_mem[caddr[9:2]];
        e.chk_dma_rd = g_dma && !dwe;
        e.dma_rd     = ref_mem[daddr[9:2]];
        sb_q.push_back(e);
        @(posedge clk);
        if (e.mem_we) ref_mem[e.mem_addr[9:2]] = e.mem_wdata;
        if (rst) begin
            m_prev_owner = 0;
            m_last_dma   = 1'b1;
            m_cpu_wait   = 0;
        end else begin
            m_prev_owner = g_cpu ? 1 : (g_dma ? 2 : 0);
            if (g_cpu)      m_last_dma = 1'b0;
            else if (g_dma) m_last_dma = 1'b1;
            m_cpu_wait = (creq && g_dma) ? m_cpu_wait + 1 : 0;
        end
        #1;
    endtask

    task automatic idle(input logic rst);
        drive(rst, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // Monitor: pop one expectation per cycle and compare on the falling edge.
    exp_t mon_e;
    int   stall_run = 0;
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check("cpu_gnt",   {31'b0, cpu_gnt},   {31'b0, mon_e.cpu_gnt});
            check("dma_gnt",   {31'b0, dma_gnt},   {31'b0, mon_e.dma_gnt});
            check("cpu_stall", {31'b0, cpu_stall}, {31'b0, mon_e.cpu_stall});
            check("mem_we",    {31'b0, mem_we},    {31'b0, mon_e.mem_we});
            check("mem_addr",  mem_addr,  mon_e.mem_addr);
            check("mem_wdata", mem_wdata, mon_e.mem_wdata);
            if (mon_e.chk_cpu_rd) check("cpu_rdata", cpu_rdata, mon_e.cpu_rd);
            if (mon_e.chk_dma_rd) check("dma_rdata", dma_rdata, mon_e.dma_rd);
            check("gnt_both",       {31'b0, cpu_gnt & dma_gnt}, 32'h0);
            check("we_without_gnt", {31'b0, mem_we & ~(cpu_gnt | dma_gnt)}, 32'h0);
            if (cpu_gnt) begin
                check("cpu_wait_bound", {31'b0, stall_run <= MB}, 32'h1);
                stall_run = 0;
            end else if (cpu_stall) begin
                stall_run++;
            end else begin
                stall_run = 0;
            end
            if (cpu_gnt || dma_gnt)
                $display("txn t=%0t %s %s addr=%h wdata=%h rdata=%h rst=%0b",
                         $time, cpu_gnt ? "CPU" : "DMA", mem_we ? "WR" : "RD",
                         mem_addr, mem_wdata, mem_rdata, reset);
        end
    end

    initial begin
        logic [DW-1:0] v;
        int            pc, pd;
        logic          r_rst, r_creq, r_cwe, r_dreq, r_dwe;
        logic [AW-1:0] r_caddr, r_daddr;

        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            tb_mem[i]  = v;
            ref_mem[i] = v;
        end
        m_prev_owner = 0;
        m_last_dma   = 1'b1;
        m_cpu_wait   = 0;

        // Reset state: no requests, no grants.
        idle(1'b1);
        idle(1'b1);

        // CPU store then load back.
        drive(1'b0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 32'h0);
        idle(1'b0);
        drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Both request from idle after reset: CPU first, then DMA alone.
        idle(1'b1);
        drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h14, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h14, 32'h0);

        // DMA owns, CPU arrives and holds: MB DMA grants then the CPU.
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h40, 32'h1111);
        for (int i = 0; i < MB + 2; i++)
            drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 32'h44 + 32'(4 * i), 32'h2000 + 32'(i));

        // DMA writes 0x55 while the CPU stalls on a store of 0xAA to the same word.
        idle(1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h24, 32'h0);
        drive(1'b0, 1'b1, 1'b1, 32'h20, 32'hAA, 1'b1, 1'b1, 32'h20, 32'h55);
        drive(1'b0, 1'b1, 1'b1, 32'h20, 32'hAA, 1'b0, 1'b0, 32'h20, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Reset in the middle of a DMA burst, then both request.
        idle(1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h30, 32'h0);
        for (int i = 0; i < 5; i++)
            drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h30, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h30, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h30, 32'h0);

        // Randomized stress with varying request densities and rare resets.
        for (int i = 0; i < 10000; i++) begin
            case ((i / 1000) % 4)
                0:       begin pc = 50; pd = 50; end
                1:       begin pc = 90; pd = 95; end
                2:       begin pc = 20; pd = 90; end
                default: begin pc = 95; pd = 30; end
            endcase
            r_rst   = ($urandom_range(0, 499) == 0);
            r_creq  = ($urandom_range(0, 99) < pc);
            r_dreq  = ($urandom_range(0, 99) < pd);
            r_cwe   = $urandom_range(0, 1) == 1;
            r_dwe   = $urandom_range(0, 1) == 1;
            r_caddr = 32'h100 + 32'($urandom_range(0, 15) * 4);
            r_daddr = 32'h100 + 32'($urandom_range(0, 15) * 4);
            drive(r_rst, r_creq, r_cwe, r_caddr, $urandom, r_dreq, r_dwe, r_daddr, $urandom);
        end

        idle(1'b0);
        @(negedge clk);
        #1;
        check("sb_drain", 32'(sb_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
